// File: rtl/neuron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neuron_pkg : shared state encoding, FP32 constants and the threshold compare |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package neuron_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACCUM   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OUTPUT  = 3'd3;
    localparam logic [2:0] ST_REFRACT = 3'd4;

    localparam logic [31:0] FP32_ZERO              = 32'h0000_0000;
    localparam logic [31:0] FP32_DEFAULT_THRESHOLD = 32'h41F0_0000;

    // For non-negative IEEE-754 values the magnitude bits order like an integer.
    function automatic logic fp32_ge_nonneg(input logic [31:0] value, input logic [31:0] thr);
        return !value[31] && (value[30:0] >= thr[30:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/Addition_Subtraction.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Addition_Subtraction : combinational FP32 adder/subtractor, round-to-even   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);

    logic        sa, sb, sl, ss;
    logic [7:0]  ea, eb, el, es, d, max_sh, sh;
    logic [23:0] ma, mb, ml, ms;
    logic [51:0] shifted;
    logic [26:0] small_al, big_al, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n;
    logic [24:0] mant;
    logic [22:0] frac;
    logic        rnd, ovf;

    always_comb begin
        sa = a_operand[31];
        sb = b_operand[31] ^ AddBar_Sub;
        ea = (a_operand[30:23] == 8'd0) ? 8'd1 : a_operand[30:23];
        eb = (b_operand[30:23] == 8'd0) ? 8'd1 : b_operand[30:23];
        ma = {(a_operand[30:23] != 8'd0), a_operand[22:0]};
        mb = {(b_operand[30:23] != 8'd0), b_operand[22:0]};

        if ({ea, ma} >= {eb, mb}) begin
            sl = sa; el = ea; ml = ma;
            ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb;
            ss = sa; es = ea; ms = ma;
        end

        // Align the smaller operand keeping guard, round and sticky bits.
        d        = el - es;
        shifted  = {ms, 28'd0} >> d;
        small_al = (d > 8'd27) ? {26'd0, |ms} : {shifted[51:26], |shifted[25:0]};
        big_al   = {ml, 3'b000};
        sum      = (sl == ss) ? ({1'b0, big_al} + {1'b0, small_al})
                              : ({1'b0, big_al} - {1'b0, small_al});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        max_sh = el - 8'd1;
        sh     = 8'd0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, el} + 10'd1;
        end else begin
            sh    = ({3'b000, lz} > max_sh) ? max_sh : {3'b000, lz};
            norm  = sum[26:0] << sh;
            exp_n = {2'b00, el} - {2'b00, sh};
            if (!norm[26]) exp_n = 10'd0;
        end

        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[26:3]} + {24'd0, rnd};
        frac = mant[22:0];
        if (mant[24]) begin
            exp_n = exp_n + 10'd1;
            frac  = mant[23:1];
        end else if ((exp_n == 10'd0) && mant[23]) begin
            exp_n = 10'd1;
        end

        ovf       = (exp_n >= 10'd255);
        Exception = (&a_operand[30:23]) | (&b_operand[30:23]) | ovf;

        if (sum == 28'd0)
            result = 32'd0;
        else if (ovf)
            result = {sl, 8'hFF, 23'd0};
        else
            result = {sl, exp_n[7:0], frac};
    end

endmodule
`default_nettype wire

// File: rtl/potential_adder_fire.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | potential_adder_fire : weight FIFO + FP32 accumulate + threshold fire      |
// | Optional refractory period: define POTENTIAL_ADDER_REFRACTORY_EN            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module potential_adder_fire
    import neuron_pkg::*;
#(
    parameter logic [31:0] THRESHOLD     = FP32_DEFAULT_THRESHOLD,
    parameter logic [31:0] V_RESET       = FP32_ZERO,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          REFRACT_STEPS = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        decay_valid,
    input  logic [31:0] decayed_potential,
    input  logic        weight_valid,
    input  logic [31:0] weight_in,
    output logic        weight_ready,
    input  logic        timestep_end,
    output logic [31:0] new_potential,
    output logic        potential_valid,
    output logic        spike,
    output logic        busy,
    output logic        fifo_overflow,
    output logic        fp_exception
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    C_DEPTH = (AW + 1)'(FIFO_DEPTH);

    logic [2:0]    state;
    logic [31:0]   acc;
    logic          ts_latch;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, draining, do_pop, do_push;
    logic [31:0]   add_result;
    logic          add_exc;
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
    logic [7:0]    refr_cnt;
    logic          spiked;
`endif

    assign full         = (count == C_DEPTH);
    assign empty        = (count == '0);
    assign weight_ready = !full;
    assign busy         = (state != ST_IDLE);
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
    assign draining = (state == ST_ACCUM) || (state == ST_REFRACT);
`else
    assign draining = (state == ST_ACCUM);
`endif
    assign do_pop  = draining && !empty;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign do_push = weight_valid && (!full || do_pop);

    Addition_Subtraction u_adder (
        .a_operand  (acc),
        .b_operand  (mem[rd_ptr]),
        .AddBar_Sub (1'b0),
        .Exception  (add_exc),
        .result     (add_result)
    );

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= weight_in;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (weight_valid && !do_push) fifo_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= ST_IDLE;
            acc             <= FP32_ZERO;
            ts_latch        <= 1'b0;
            new_potential   <= FP32_ZERO;
            potential_valid <= 1'b0;
            spike           <= 1'b0;
            fp_exception    <= 1'b0;
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
            refr_cnt        <= 8'd0;
            spiked          <= 1'b0;
`endif
        end else begin
            if (state == ST_OUTPUT)
                ts_latch <= 1'b0;
            else if (timestep_end && ((state != ST_IDLE) || decay_valid))
                ts_latch <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (decay_valid) begin
                        acc   <= decayed_potential;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (do_pop) begin
                        if (add_exc) fp_exception <= 1'b1;
                        else         acc          <= add_result;
                    end else if (ts_latch) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    potential_valid <= 1'b1;
                    state           <= ST_OUTPUT;
                    if (fp32_ge_nonneg(acc, THRESHOLD)) begin
                        acc           <= V_RESET;
                        new_potential <= V_RESET;
                        spike         <= 1'b1;
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
                        spiked        <= 1'b1;
`endif
                    end else begin
                        new_potential <= acc;
                    end
                end
                ST_OUTPUT: begin
                    potential_valid <= 1'b0;
                    spike           <= 1'b0;
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
                    spiked          <= 1'b0;
                    if (spiked && (REFRACT_STEPS != 0)) begin
                        refr_cnt <= 8'(REFRACT_STEPS);
                        state    <= ST_REFRACT;
                    end else if (refr_cnt != 8'd0) begin
                        state    <= ST_REFRACT;
                    end else begin
                        state    <= ST_IDLE;
                    end
`else
                    state           <= ST_IDLE;
`endif
                end
`ifdef POTENTIAL_ADDER_REFRACTORY_EN
                // Weights of a refractory timestep are popped and thrown away.
                ST_REFRACT: begin
                    if (!do_pop && ts_latch) begin
                        acc             <= V_RESET;
                        new_potential   <= V_RESET;
                        potential_valid <= 1'b1;
                        refr_cnt        <= refr_cnt - 8'd1;
                        state           <= ST_OUTPUT;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_potential_adder_fire.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_potential_adder_fire : random timesteps vs real-arithmetic neuron model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_potential_adder_fire;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        decay_valid = 1'b0;
    logic [31:0] decayed_potential = 32'd0;
    logic        weight_valid = 1'b0;
    logic [31:0] weight_in = 32'd0;
    logic        weight_ready;
    logic        timestep_end = 1'b0;
    logic [31:0] new_potential;
    logic        potential_valid, spike, busy, fifo_overflow, fp_exception;

    always #5 clk = ~clk;

    potential_adder_fire dut (
        .CLK               (clk),
        .RESET_N           (rst_n),
        .decay_valid       (decay_valid),
        .decayed_potential (decayed_potential),
        .weight_valid      (weight_valid),
        .weight_in         (weight_in),
        .weight_ready      (weight_ready),
        .timestep_end      (timestep_end),
        .new_potential     (new_potential),
        .potential_valid   (potential_valid),
        .spike             (spike),
        .busy              (busy),
        .fifo_overflow     (fifo_overflow),
        .fp_exception      (fp_exception)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pending[$];
    logic        exp_ovf = 1'b0;
    logic        exp_exc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Only values exactly representable in FP32 are used, so the model is exact.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int          ex;
        if (r == 0.0) return 32'd0;
        b  = $realtobits(r);
        ex = int'(b[62:52]) - 896;
        return {b[63], ex[7:0], b[51:29]};
    endfunction

    task automatic push_weight(input logic [31:0] w);
        @(posedge clk); #1;
        weight_valid = 1'b1;
        weight_in    = w;
        @(posedge clk); #1;
        weight_valid = 1'b0;
        if (pending.size() < 4) pending.push_back(w);
        else                    exp_ovf = 1'b1;
    endtask

    task automatic run_timestep(input logic [31:0] dec, input string tag);
        real         acc;
        int          n, lat;
        logic        done, fire;
        logic [31:0] exp_np;
        n   = pending.size();
        acc = f2r(dec);
        foreach (pending[i]) begin
            if (&pending[i][30:23]) exp_exc = 1'b1;
            else                    acc = acc + f2r(pending[i]);
        end
        pending.delete();
        fire   = (acc >= 30.0);
        exp_np = fire ? 32'd0 : r2f(acc);

        @(posedge clk); #1;
        decay_valid       = 1'b1;
        timestep_end      = 1'b1;
        decayed_potential = dec;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            decay_valid  = 1'b0;
            timestep_end = 1'b0;
            lat++;
            @(negedge clk);
            if (potential_valid) done = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(n + 3));
        check({tag, "_potential"}, new_potential, exp_np);
        check({tag, "_spike"}, {31'd0, spike}, {31'd0, fire});
        check({tag, "_busy_out"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, potential_valid}, 32'd0);
        check({tag, "_hold"}, new_potential, exp_np);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_ovf"}, {31'd0, fifo_overflow}, {31'd0, exp_ovf});
        check({tag, "_exc"}, {31'd0, fp_exception}, {31'd0, exp_exc});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_np"}, new_potential, 32'd0);
        check({tag, "_pv"}, {31'd0, potential_valid}, 32'd0);
        check({tag, "_spike"}, {31'd0, spike}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ovf"}, {31'd0, fifo_overflow}, 32'd0);
        check({tag, "_exc"}, {31'd0, fp_exception}, 32'd0);
        check({tag, "_ready"}, {31'd0, weight_ready}, 32'd1);
    endtask

    initial begin
        int pv_seen;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 20; t++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++)
                push_weight(r2f(real'(int'($urandom_range(0, 32)) - 16) * 0.5));
            run_timestep(r2f(real'(int'($urandom_range(0, 320)) - 160) * 0.25), "rand");
        end

        push_weight(32'h4000_0000);
        run_timestep(32'h41DE_D852, "below_thr");
        check("below_thr_value", new_potential, 32'h41EE_D852);

        push_weight(32'h4000_0000);
        push_weight(32'h3FC0_0000);
        run_timestep(32'h41DE_D852, "fire");

        push_weight(r2f(30.0));
        run_timestep(32'd0, "exact_thr");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ready_before_push", {31'd0, weight_ready}, {31'd0, (i < 4)});
            push_weight(32'h3F80_0000);
        end
        @(negedge clk);
        check("ready_full", {31'd0, weight_ready}, 32'd0);
        check("overflow_sticky", {31'd0, fifo_overflow}, 32'd1);
        run_timestep(32'h4000_0000, "drain_full");

        push_weight(32'h7F80_0000);
        run_timestep(32'h3F80_0000, "inf_weight");

        push_weight(32'h4000_0000);
        push_weight(32'h4000_0000);
        @(posedge clk); #1;
        decay_valid       = 1'b1;
        decayed_potential = 32'h3F80_0000;
        @(posedge clk); #1;
        decay_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        pv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (potential_valid) pv_seen++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (potential_valid) pv_seen++;
        end
        check("midop_no_pulse", 32'(pv_seen), 32'd0);
        pending.delete();
        exp_ovf = 1'b0;
        exp_exc = 1'b0;
        run_timestep(32'h3F80_0000, "after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/potential_adder_fire.md
POTENTIAL_ADDER_FIRE -- requirements
Module: potential_adder_fire

Interface
REQ-001 SHALL provide parameter THRESHOLD, default 32'h41F00000 (+30.0 FP32), positive firing threshold.
REQ-002 SHALL provide parameter V_RESET, default 32'h00000000, post-spike potential.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, weight FIFO entries (power of 2, 2..16).
REQ-004 SHALL provide parameter REFRACT_STEPS, default 2, refractory timesteps (used only with REFRACTORY_EN).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock; RESET_N in 1, asynchronous active-low reset.
REQ-006 SHALL have decay_valid in 1: one-cycle pulse, decayed potential present.
REQ-007 SHALL have decayed_potential in 32: FP32 output of the decay stage.
REQ-008 SHALL have weight_valid in 1 and weight_in in 32: FP32 synaptic weight push.
REQ-009 SHALL have weight_ready out 1: FIFO not full.
REQ-010 SHALL have timestep_end in 1: pulse, no further weights this timestep.
REQ-011 SHALL have new_potential out 32: updated potential, fed back to the decay stage.
REQ-012 SHALL have potential_valid out 1 and spike out 1: one-cycle pulses.
REQ-013 SHALL have busy out 1, fifo_overflow out 1 (sticky) and fp_exception out 1 (sticky).

Function
REQ-014 SHALL implement states IDLE, ACCUM, CHECK, OUTPUT, plus REFRACT when REFRACTORY_EN is defined.
REQ-015 In IDLE, decay_valid SHALL load acc <= decayed_potential and move to ACCUM next cycle; busy=1 in every state except IDLE.
REQ-016 decay_valid outside IDLE SHALL be ignored.
REQ-017 timestep_end SHALL be latched from the decay_valid cycle onward, cleared on leaving OUTPUT, and ignored in IDLE without decay_valid.
REQ-018 In ACCUM, SHALL pop one weight per cycle when the FIFO is non-empty, with acc <= FP32 sum(acc, weight).
REQ-019 An adder Exception SHALL leave acc unchanged, discard the weight and set fp_exception.
REQ-020 ACCUM SHALL go to CHECK when the timestep_end latch is set and the FIFO is empty.
REQ-021 CHECK SHALL fire when acc[31]==0 and acc[30:0] >= THRESHOLD[30:0]; on fire acc <= V_RESET and a spike is flagged.
REQ-022 OUTPUT SHALL assert potential_valid=1 and new_potential=acc for one cycle, with spike=1 in that same cycle if flagged, then return to IDLE.
REQ-023 Latency from decay_valid to potential_valid SHALL be 3+N cycles for N queued weights, given timestep_end arrives no later than the last pop.
REQ-024 The FIFO SHALL accept pushes in any state when weight_ready=1.
REQ-025 A push and a pop in the same cycle SHALL both occur, leaving the count unchanged; this SHALL apply even when full.
REQ-026 weight_valid while full SHALL drop the weight and set fifo_overflow.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 new_potential SHALL hold its value between potential_valid pulses.

Reset
REQ-029 RESET_N low SHALL immediately force IDLE, empty the FIFO, and clear acc, the timestep_end latch and refractory count.
REQ-030 RESET_N low SHALL clear new_potential=0, potential_valid=0, spike=0, busy=0, fifo_overflow=0, fp_exception=0; weight_ready SHALL be 1.
REQ-031 Reset mid-operation SHALL discard the in-flight timestep with no output pulse.
REQ-032 Sticky flags SHALL clear only on reset.

Configuration
REQ-033 Macro POTENTIAL_ADDER_REFRACTORY_EN defined: after a spike, OUTPUT SHALL go to REFRACT for REFRACT_STEPS timesteps.
REQ-034 In REFRACT, each timestep SHALL pop and discard weights until the timestep_end latch is set and the FIFO is empty, then emit potential_valid with new_potential=V_RESET and spike=0.
REQ-035 Macro POTENTIAL_ADDER_REFRACTORY_EN undefined: the REFRACT state and its counter SHALL be absent, and OUTPUT SHALL always return to IDLE.

Structure
REQ-036 Shared package neuron_pkg SHALL hold the state encoding, FP32 constants (zero, default threshold) and the FP32 non-negative compare function.
REQ-037 SHALL instantiate the existing Addition_Subtraction adder once as the single sub-module; the FIFO SHALL be inline.

Verification
REQ-038 decayed 41DED852 (~27.86), weights 40000000 (2.0), timestep_end -> new_potential ~29.86 (41EED852), spike=0, latency 4.
REQ-039 decayed 41DED852, weights 40000000 and 3FC00000, timestep_end -> spike=1, new_potential=00000000, latency 5.
REQ-040 5 pushes with FIFO_DEPTH=4 in IDLE -> weight_ready=0 after 4 pushes, 5th push dropped, fifo_overflow=1.
REQ-041 weight 7F800000 (+inf) -> fp_exception=1, acc unchanged, no spike from that weight.
REQ-042 RESET_N low during ACCUM with 2 weights queued -> all outputs 0, weight_ready=1, no potential_valid.
REQ-043 With POTENTIAL_ADDER_REFRACTORY_EN: spike, then 2 timesteps each of 40000000 weights -> both outputs 00000000 with spike=0; third timestep accumulates normally.
